// File: rtl/lcd_port_if.sv
// Signal bundle between the control CPU streams, the LCD/button pins and lcd_port_controller.
// The master side is the CPU plus pin readback. The slave side is the controller.
interface lcd_port_if;
  logic [31:0] lcd_in;
  logic        lcd_in_stb;
  logic        lcd_in_ack;
  logic [3:0]  lcd_data_out;
  logic        lcd_rs_out;
  logic        lcd_oe;
  logic        lcd_e;
  logic [3:0]  lcd_data_in;
  logic        lcd_rs_in;
  logic [4:0]  pb_out;

  modport master (
    output lcd_in, lcd_in_stb, lcd_data_in, lcd_rs_in,
    input  lcd_in_ack, lcd_data_out, lcd_rs_out, lcd_oe, lcd_e, pb_out
  );

  modport slave (
    input  lcd_in, lcd_in_stb, lcd_data_in, lcd_rs_in,
    output lcd_in_ack, lcd_data_out, lcd_rs_out, lcd_oe, lcd_e, pb_out
  );
endinterface

// File: rtl/lcd_port_controller.sv
// Sends HD44780 bytes as timed 4-bit nibble pairs on the shared LCD/button port.
// While the bus is idle it debounces the push buttons that share the same pins.
module lcd_port_controller #(
  parameter int SETUP_CYCLES     = 4,
  parameter int E_HIGH_CYCLES    = 16,
  parameter int HOLD_CYCLES      = 16,
  parameter int CMD_WAIT_CYCLES  = 2500,
  parameter int LONG_WAIT_CYCLES = 100000,
  parameter int SETTLE_CYCLES    = 8,
  parameter int DEBOUNCE_CYCLES  = 500000
) (
  input logic       clk,
  input logic       rst,
  lcd_port_if.slave bus
);

  localparam logic [31:0] SETUP_LD  = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] EHIGH_LD  = 32'(E_HIGH_CYCLES - 1);
  localparam logic [31:0] HOLD_LD   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] CMD_LD    = 32'(CMD_WAIT_CYCLES - 1);
  localparam logic [31:0] LONG_LD   = 32'(LONG_WAIT_CYCLES - 1);
  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] DB_MAX    = 32'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHIGH,
    HOLD,
    WAIT,
    SETTLE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        nib_q, nib_d;
  logic        second_q, second_d;

  logic        ack_q, oe_q, e_q, rs_out_q;
  logic [3:0]  data_q;

  logic [4:0]  sync1_q, sync2_q;
  logic [4:0]  cand_q, cand_d;
  logic [31:0] db_q, db_d;
  logic [4:0]  pb_q, pb_d;

  logic        longWait;
  logic        drive_d;
  logic [3:0]  nibble_d;
  logic        unused_lcd_in;

  assign unused_lcd_in = ^bus.lcd_in[31:10];

  // Clear, home and nibble-only writes need the long execution wait.
  assign longWait = nib_q || (!rs_q && (byte_q[7:2] == 6'd0));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    nib_d    = nib_q;
    second_d = second_q;
    case (state_q)
      IDLE: begin
        if (bus.lcd_in_stb) begin
          byte_d   = bus.lcd_in[7:0];
          rs_d     = bus.lcd_in[8];
          nib_d    = bus.lcd_in[9];
          second_d = 1'b0;
          state_d  = SETUP;
          cnt_d    = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q == 32'd0) begin
          state_d = EHIGH;
          cnt_d   = EHIGH_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      EHIGH: begin
        if (cnt_q == 32'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 32'd0) begin
          if (!second_q && !nib_q) begin
            second_d = 1'b1;
            state_d  = SETUP;
            cnt_d    = SETUP_LD;
          end else begin
            state_d = WAIT;
            cnt_d   = longWait ? LONG_LD : CMD_LD;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      WAIT: begin
        if (cnt_q == 32'd0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 32'd0) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SETTLE;
      cnt_q    <= SETTLE_LD;
      byte_q   <= 8'd0;
      rs_q     <= 1'b0;
      nib_q    <= 1'b0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      nib_q    <= nib_d;
      second_q <= second_d;
    end
  end

  // Pin outputs are registered from the next state, so the data and E edges never glitch.
  assign drive_d  = (state_d == SETUP) || (state_d == EHIGH) ||
                    (state_d == HOLD)  || (state_d == WAIT);
  assign nibble_d = second_d ? byte_d[3:0] : byte_d[7:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      oe_q     <= 1'b0;
      e_q      <= 1'b0;
      data_q   <= 4'd0;
      rs_out_q <= 1'b0;
    end else begin
      ack_q    <= (state_d == IDLE);
      oe_q     <= drive_d;
      e_q      <= (state_d == EHIGH);
      data_q   <= drive_d ? nibble_d : 4'd0;
      rs_out_q <= drive_d ? rs_d : 1'b0;
    end
  end

  // The debounce state only advances in IDLE, so our own driven nibbles are never sampled.
  always_comb begin
    cand_d = cand_q;
    db_d   = db_q;
    pb_d   = pb_q;
    if (state_q == IDLE) begin
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        db_d   = 32'd0;
      end else if (db_q != DB_MAX) begin
        db_d = db_q + 32'd1;
      end
      if (db_d == DB_MAX) begin
        pb_d = cand_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 5'b11111;
      sync2_q <= 5'b11111;
      cand_q  <= 5'b11111;
      db_q    <= 32'd0;
      pb_q    <= 5'b11111;
    end else begin
      sync1_q <= {bus.lcd_rs_in, bus.lcd_data_in};
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      db_q    <= db_d;
      pb_q    <= pb_d;
    end
  end

  assign bus.lcd_in_ack   = ack_q;
  assign bus.lcd_oe       = oe_q;
  assign bus.lcd_e        = e_q;
  assign bus.lcd_data_out = data_q;
  assign bus.lcd_rs_out   = rs_out_q;
  assign bus.pb_out       = pb_q;

endmodule

// File: tb/tb_lcd_port_controller.sv
// Randomised bench for lcd_port_controller against a transaction-level timing and debounce model.
// Model position in a transfer is a cycle index, and expected pin values are derived arithmetically from it.
module tb_lcd_port_controller;
  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 3;
  localparam int CW = 10;
  localparam int LW = 40;
  localparam int T  = 2;
  localparam int DB = 5;
  localparam int P  = S + E + H;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lcd_port_if bus();

  lcd_port_controller #(
    .SETUP_CYCLES(S), .E_HIGH_CYCLES(E), .HOLD_CYCLES(H),
    .CMD_WAIT_CYCLES(CW), .LONG_WAIT_CYCLES(LW),
    .SETTLE_CYCLES(T), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checkCount = 0;
  int errorCount = 0;

  int         mT, mTotal, mNib, mWait, mRun;
  logic [7:0] mByte;
  logic       mRs;
  logic [4:0] mCand, mPb, syncA, syncB;

  int         eRises;
  int         obsAccepts;
  logic       prevE;
  logic [4:0] curPins;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    mT     = 0;
    mTotal = T;
    mNib   = 0;
    mWait  = 0;
    mByte  = 8'd0;
    mRs    = 1'b0;
    mCand  = 5'h1f;
    mRun   = 1;
    mPb    = 5'h1f;
    syncA  = 5'h1f;
    syncB  = 5'h1f;
  endtask

  // Expected pin state from the cycle index c within the current transfer.
  task automatic checkNow();
    int         c, k;
    logic       busy, expOe, expE;
    logic [3:0] expData;
    busy  = (mT < mTotal);
    c     = mT + 1;
    expOe = busy && (c <= mNib * P + mWait);
    expE  = busy && (c <= mNib * P) && (((c - 1) % P) >= S) && (((c - 1) % P) < S + E);
    k = (c - 1) / P;
    if (k > mNib - 1) k = mNib - 1;
    expData = (k <= 0) ? mByte[7:4] : mByte[3:0];
    checkOutput("ack", 32'(bus.lcd_in_ack), 32'(!busy));
    checkOutput("oe", 32'(bus.lcd_oe), 32'(expOe));
    checkOutput("e", 32'(bus.lcd_e), 32'(expE));
    if (expOe) begin
      checkOutput("data", 32'(bus.lcd_data_out), 32'(expData));
      checkOutput("rs", 32'(bus.lcd_rs_out), 32'(mRs));
    end
    checkOutput("pb", 32'(bus.pb_out), 32'(mPb));
  endtask

  task automatic modelEdge(input logic stb, input logic [31:0] din, input logic [4:0] pins);
    logic       idle;
    logic [4:0] sample;
    idle = !(mT < mTotal);
    if (idle) begin
      sample = syncB;
      if (sample == mCand) begin
        if (mRun < DB) mRun++;
      end else begin
        mCand = sample;
        mRun  = 1;
      end
      if (mRun >= DB) mPb = mCand;
    end
    syncB = syncA;
    syncA = pins;
    if (idle && stb) begin
      mByte  = din[7:0];
      mRs    = din[8];
      mNib   = din[9] ? 1 : 2;
      mWait  = (din[9] || (!din[8] && din[7:0] < 8'd4)) ? LW : CW;
      mTotal = mNib * P + mWait + T;
      mT     = 0;
    end else if (!idle) begin
      mT++;
    end
  endtask

  task automatic applyStimulus(input logic stb, input logic [31:0] din, input logic [4:0] pins);
    checkNow();
    if (bus.lcd_e && !prevE) eRises++;
    prevE = bus.lcd_e;
    bus.lcd_in_stb  = stb;
    bus.lcd_in      = din;
    bus.lcd_rs_in   = pins[4];
    bus.lcd_data_in = pins[3:0];
    if (bus.lcd_in_ack && stb) obsAccepts++;
    @(posedge clk);
    modelEdge(stb, din, pins);
    @(negedge clk);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_e", 32'(bus.lcd_e), 32'd0);
    checkOutput("rst_oe", 32'(bus.lcd_oe), 32'd0);
    checkOutput("rst_ack", 32'(bus.lcd_in_ack), 32'd0);
    checkOutput("rst_data", 32'(bus.lcd_data_out), 32'd0);
    checkOutput("rst_rs", 32'(bus.lcd_rs_out), 32'd0);
    checkOutput("rst_pb", 32'(bus.pb_out), 32'h1f);
  endtask

  initial begin
    bus.lcd_in_stb  = 1'b0;
    bus.lcd_in      = 32'd0;
    bus.lcd_rs_in   = 1'b1;
    bus.lcd_data_in = 4'hf;
    prevE      = 1'b0;
    eRises     = 0;
    obsAccepts = 0;
    curPins    = 5'h1f;

    #1 rst = 1'b1;
    #1 checkResetValues();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    repeat (4) applyStimulus(1'b0, 32'd0, 5'h1f);

    // Normal data byte: two enable pulses, CMD wait.
    eRises = 0;
    applyStimulus(1'b1, 32'h141, 5'h1f);
    repeat (30) applyStimulus(1'b0, 32'h141, 5'h1f);
    checkOutput("pulses_141", 32'(eRises), 32'd2);

    applyStimulus(1'b1, 32'h001, 5'h1f);
    repeat (60) applyStimulus(1'b0, 32'h001, 5'h1f);
    applyStimulus(1'b1, 32'h004, 5'h1f);
    repeat (30) applyStimulus(1'b0, 32'h004, 5'h1f);

    // Nibble-only write: a single enable pulse, long wait.
    eRises = 0;
    applyStimulus(1'b1, 32'h230, 5'h1f);
    repeat (52) applyStimulus(1'b0, 32'h230, 5'h1f);
    checkOutput("pulses_230", 32'(eRises), 32'd1);

    // Debounce: settle to 11110, glitch back for 3 cycles, then freeze across a write.
    repeat (10) applyStimulus(1'b0, 32'd0, 5'h1e);
    checkOutput("pb_stable", 32'(bus.pb_out), 32'h1e);
    repeat (3) applyStimulus(1'b0, 32'd0, 5'h1f);
    repeat (10) applyStimulus(1'b0, 32'd0, 5'h1e);
    checkOutput("pb_glitch", 32'(bus.pb_out), 32'h1e);
    repeat (3) applyStimulus(1'b0, 32'd0, 5'h1c);
    applyStimulus(1'b1, 32'h141, 5'h1c);
    repeat (30) applyStimulus(1'b0, 32'h141, 5'h1c);
    repeat (10) applyStimulus(1'b0, 32'd0, 5'h1c);
    checkOutput("pb_frozen", 32'(bus.pb_out), 32'h1c);

    // Asynchronous reset while E is high.
    applyStimulus(1'b1, 32'h141, 5'h1f);
    repeat (S) applyStimulus(1'b0, 32'h141, 5'h1f);
    checkOutput("e_before_rst", 32'(bus.lcd_e), 32'd1);
    #2 rst = 1'b1;
    #1 checkResetValues();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    prevE = 1'b0;
    repeat (5) applyStimulus(1'b0, 32'd0, 5'h1f);

    // Strobe held across three back-to-back writes.
    obsAccepts = 0;
    repeat (3 * 28) applyStimulus(1'b1, 32'h141, 5'h1f);
    checkOutput("held_accepts", 32'(obsAccepts), 32'd3);
    repeat (30) applyStimulus(1'b0, 32'd0, 5'h1f);

    // Random traffic and button activity.
    for (int i = 0; i < 800; i++) begin
      logic        stb;
      logic [31:0] din;
      if ($urandom_range(0, 7) == 0) curPins = 5'($urandom_range(0, 31));
      stb = ($urandom_range(0, 3) == 0);
      din = $urandom;
      applyStimulus(stb, din, curPins);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/lcd_port_controller.md
# lcd_port_controller

Hardware sequencer for the shared LCD/push-button port on the MAX1000 transceiver board. It sits between the control CPU's `lcd_out` stream and the top-level tri-state pins `lcd_data[3:0]`, `lcd_rs` and `lcd_e`, and replaces per-bit CPU bit-banging. It accepts whole HD44780 bytes, plays them out as two 4-bit nibbles with parameterised enable timing and execution waits, then releases the bus. While the bus is idle it samples and debounces the five push buttons that share those pins, and presents them on the CPU `pb_in` stream.

## Interface
- `SETUP_CYCLES`, default 4: cycles that data and RS are valid before `lcd_e` rises.
- `E_HIGH_CYCLES`, default 16: `lcd_e` high time, in cycles.
- `HOLD_CYCLES`, default 16: cycles with `lcd_e` low after each nibble, data still driven.
- `CMD_WAIT_CYCLES`, default 2500: execution wait for normal bytes (50 µs at 50 MHz).
- `LONG_WAIT_CYCLES`, default 100000: execution wait for clear, home and nibble-only writes (2 ms).
- `SETTLE_CYCLES`, default 8: cycles after the bus is released before button sampling resumes.
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable samples needed to accept a button state.
- `clk`, in, 1: `clk_50` domain.
- `rst`, in, 1: asynchronous, active-high.
- `lcd_in`, in, 32: bits [7:0] byte, bit [8] RS, bit [9] nibble_only. Other bits are ignored.
- `lcd_in_stb`, in, 1: CPU write strobe. It is held until acknowledged.
- `lcd_in_ack`, out, 1: high only in IDLE. A transfer occurs on the edge where `lcd_in_stb` and `lcd_in_ack` are both high.
- `lcd_data_out`, out, 4: nibble driven to the pins.
- `lcd_rs_out`, out, 1: RS driven to the pin.
- `lcd_oe`, out, 1: output enable for the top-level tri-state buffers on `lcd_data` and `lcd_rs`.
- `lcd_e`, out, 1: LCD enable strobe.
- `lcd_data_in`, in, 4: raw pin readback of `lcd_data`.
- `lcd_rs_in`, in, 1: raw pin readback of `lcd_rs`.
- `pb_out`, out, 5: debounced button state `{rs, data[3:0]}`. This feeds `pb_in`; its strobe is tied high at top level.

## Operation
- States: IDLE, SETUP, EHIGH, HOLD, WAIT, SETTLE. A 1-bit `second` flag tracks which nibble is being sent.
- Every timed state lasts exactly its parameter's number of cycles. The state counter loads PARAM-1 on entry and exits at 0. All parameters must be ≥1.
- **Accept:** on an accepting edge, latch byte, RS and nibble_only, set `second`=0, and go to SETUP.
- **SETUP:**
  - `lcd_oe`=1, `lcd_e`=0, `lcd_rs_out`=latched RS.
  - `lcd_data_out` = byte[7:4] when `second`=0, byte[3:0] when `second`=1.
- **EHIGH:** same drive as SETUP, with `lcd_e`=1.
- **HOLD:** same drive as SETUP, with `lcd_e`=0.
- **HOLD exit:**
  - If `second`=0 and nibble_only=0: set `second`=1 and go to SETUP.
  - Otherwise: go to WAIT.
- **WAIT:**
  - `lcd_oe` stays 1 and data is held.
  - Duration is LONG_WAIT_CYCLES when nibble_only=1, or when RS=0 and byte[7:2]==0 (bytes 0x00–0x03). Otherwise it is CMD_WAIT_CYCLES.
- **SETTLE:** `lcd_oe`=0 and `lcd_e`=0, then go to IDLE.
- **IDLE:** `lcd_oe`=0 and `lcd_in_ack`=1.
- **Button sampling:**
  - Sampling happens only in IDLE. Each sample is `{lcd_rs_in, lcd_data_in}`, through a 2-flop synchroniser; the synchroniser runs always.
  - When the sample differs from the candidate register: candidate ← sample and the counter is cleared.
  - When the sample equals the candidate: the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - On the cycle the counter reaches DEBOUNCE_CYCLES-1: `pb_out` ← candidate.
  - Outside IDLE the counter and candidate freeze, so writes never inject the driven nibble into `pb_out`.
- **Reset (asserted at any time, including mid-transfer):**
  - Outputs: `lcd_e`=0, `lcd_oe`=0, `lcd_data_out`=0, `lcd_rs_out`=0, `lcd_in_ack`=0, `pb_out`=5'b11111 (pulled-up buttons released).
  - Internal: candidate=5'b11111, counter=0, state=SETTLE.
- A partially sent byte is discarded; the CPU re-initialises the LCD.

## Timing
- `lcd_in_ack` is a registered decode of state: high throughout IDLE, low from the cycle after the accepting edge.
- Drive timing: `lcd_oe` and the high nibble appear on the first cycle after the accepting edge. `lcd_e` first rises SETUP_CYCLES cycles after that.
- Full byte: `lcd_in_ack` reasserts exactly 2·(S+E+H)+W+T cycles after the accepting edge. Nibble-only: (S+E+H)+LONG_WAIT+T.
- After reset deassertion, `lcd_in_ack` first rises after SETTLE_CYCLES cycles.
- `lcd_e` never rises in the same cycle as a change of `lcd_data_out` or `lcd_rs_out`.
- `lcd_oe` never falls while `lcd_e`=1.
- A `lcd_in_stb` that is high outside IDLE is ignored until IDLE. Back-to-back writes give no extra bubble.

## Test plan
Bench parameters: S=2, E=3, H=3, CMD_WAIT=10, LONG_WAIT=40, T=2, DEBOUNCE=5.
- **Normal byte:** write 0x141 with RS=1, byte 0x41 → `lcd_data_out` 0x4 then 0x1, `lcd_rs_out`=1, two `lcd_e` pulses of 3 cycles each, ack returns 28 cycles after accept.
- **Long-wait command:** write 0x001 (clear) → LONG_WAIT path, ack returns 58 cycles after accept. Write 0x004 → CMD_WAIT path, 28 cycles.
- **Nibble-only:** write 0x230 → exactly one `lcd_e` pulse with data 0x3, ack returns 50 cycles after accept.
- **Debounce:**
  - Pins go to 5'b11110 in IDLE → `pb_out` updates on the 5th stable sample.
  - A 3-cycle glitch → no change.
  - A write issued mid-count freezes the count; it resumes after SETTLE.
- **Reset mid-EHIGH:** assert `rst` asynchronously while `lcd_e`=1 → `lcd_e`, `lcd_oe` and `lcd_in_ack` go to 0 immediately. Ack returns 2 cycles after release.
- **Held strobe:** hold `lcd_in_stb` high across 3 writes → exactly 3 accepts, each 28 cycles apart, and `lcd_oe` is low during every SETTLE and IDLE.
